// File: rtl/inst_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_sequencer_if : FIFO handshake and ALU control bundle for the sequencer |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface inst_sequencer_if #(
  parameter int DATA_WIDTH   = 4,
  parameter int INST_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 2
);
  logic [INST_WIDTH-1:0]   ctrl_fifo_data_out;
  logic                    ctrl_fifo_empty;
  logic                    ctrl_fifo_deq;
  logic [DATA_WIDTH-1:0]   int_fifo_data_out;
  logic                    int_fifo_empty;
  logic                    int_fifo_deq;
  logic [DATA_WIDTH-1:0]   nin_fifo_data_out;
  logic                    nin_fifo_empty;
  logic                    nin_fifo_deq;
  logic                    nout_fifo_full;
  logic                    nout_fifo_enq;
  logic [DATA_WIDTH-1:0]   nout_fifo_data_in;
  logic                    bus_fifo_full;
  logic                    bus_fifo_enq;
  logic [DATA_WIDTH-1:0]   bus_fifo_data_in;
  logic                    alu_enable;
  logic [OPCODE_WIDTH-1:0] alu_op_code;
  logic [DATA_WIDTH-1:0]   alu_op0;
  logic [DATA_WIDTH-1:0]   alu_op1;
  logic [DATA_WIDTH-1:0]   alu_out;
  logic                    busy;
  logic                    inst_done;

  modport master (
    input  ctrl_fifo_data_out, ctrl_fifo_empty,
    input  int_fifo_data_out, int_fifo_empty,
    input  nin_fifo_data_out, nin_fifo_empty,
    input  nout_fifo_full, bus_fifo_full, alu_out,
    output ctrl_fifo_deq, int_fifo_deq, nin_fifo_deq,
    output nout_fifo_enq, nout_fifo_data_in, bus_fifo_enq, bus_fifo_data_in,
    output alu_enable, alu_op_code, alu_op0, alu_op1, busy, inst_done
  );

  modport slave (
    output ctrl_fifo_data_out, ctrl_fifo_empty,
    output int_fifo_data_out, int_fifo_empty,
    output nin_fifo_data_out, nin_fifo_empty,
    output nout_fifo_full, bus_fifo_full, alu_out,
    input  ctrl_fifo_deq, int_fifo_deq, nin_fifo_deq,
    input  nout_fifo_enq, nout_fifo_data_in, bus_fifo_enq, bus_fifo_data_in,
    input  alu_enable, alu_op_code, alu_op0, alu_op1, busy, inst_done
  );
endinterface
`default_nettype wire

// File: rtl/inst_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | inst_sequencer : FETCH/OP0/OP1/EXEC/WB control unit for the stream processor|
// | Optional perf counters under INST_SEQ_PERF_CNT_EN.        Rev 1.0           |
// +----------------------------------------------------------------------------+
module inst_sequencer #(
  parameter int DATA_WIDTH     = 4,
  parameter int INST_WIDTH     = 8,
  parameter int OPCODE_WIDTH   = 2,
  parameter int SRC0_IDX_WIDTH = 2,
  parameter int SRC1_IDX_WIDTH = 2,
  parameter int DST0_IDX_WIDTH = 1,
  parameter int DST1_IDX_WIDTH = 1
) (
  input  wire              clk,
  input  wire              reset,
  inst_sequencer_if.master sif
`ifdef INST_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]      retired_cnt,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int SRC1_LSB = DST0_IDX_WIDTH + DST1_IDX_WIDTH;
  localparam int SRC0_LSB = SRC1_LSB + SRC1_IDX_WIDTH;
  localparam int OPC_LSB  = SRC0_LSB + SRC0_IDX_WIDTH;
  localparam int SEL_W    = (SRC0_IDX_WIDTH > SRC1_IDX_WIDTH) ? SRC0_IDX_WIDTH : SRC1_IDX_WIDTH;

  localparam logic [SEL_W-1:0] SEL_INT = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_NIN = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_ACC = SEL_W'(2);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_OP0   = 3'd1,
    S_OP1   = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [INST_WIDTH-1:0]   inst_q, inst_d;
  logic [DATA_WIDTH-1:0]   op0_q, op0_d;
  logic [DATA_WIDTH-1:0]   alu_op0_q, alu_op0_d;
  logic [DATA_WIDTH-1:0]   alu_op1_q, alu_op1_d;
  logic [OPCODE_WIDTH-1:0] alu_opc_q, alu_opc_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;

  logic [OPCODE_WIDTH-1:0] opcode_w;
  logic [SEL_W-1:0]        src0_w, src1_w, sel_w;
  logic                    dst0_w, dst1_w;
  logic                    src_ready_w, wb_ready_w;
  logic [DATA_WIDTH-1:0]   src_val_w;

  logic ctrl_deq_w, int_deq_w, nin_deq_w, nout_enq_w, bus_enq_w, alu_en_w, done_w;

  assign opcode_w = inst_q[OPC_LSB +: OPCODE_WIDTH];
  assign src0_w   = SEL_W'(inst_q[SRC0_LSB +: SRC0_IDX_WIDTH]);
  assign src1_w   = SEL_W'(inst_q[SRC1_LSB +: SRC1_IDX_WIDTH]);
  assign dst0_w   = inst_q[DST1_IDX_WIDTH];
  assign dst1_w   = inst_q[0];

  // One operand mux serves both OP0 and OP1; only the selector differs.
  always_comb begin
    sel_w       = (state_q == S_OP0) ? src0_w : src1_w;
    src_ready_w = 1'b1;
    src_val_w   = '0;
    case (sel_w)
      SEL_INT: begin
        src_ready_w = !sif.int_fifo_empty;
        src_val_w   = sif.int_fifo_data_out;
      end
      SEL_NIN: begin
        src_ready_w = !sif.nin_fifo_empty;
        src_val_w   = sif.nin_fifo_data_out;
      end
      SEL_ACC: src_val_w = acc_q;
      default: src_val_w = '0;
    endcase
    wb_ready_w = (!dst0_w || !sif.nout_fifo_full) && (!dst1_w || !sif.bus_fifo_full);
  end

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    op0_d      = op0_q;
    alu_op0_d  = alu_op0_q;
    alu_op1_d  = alu_op1_q;
    alu_opc_d  = alu_opc_q;
    acc_d      = acc_q;
    result_d   = result_q;
    ctrl_deq_w = 1'b0;
    int_deq_w  = 1'b0;
    nin_deq_w  = 1'b0;
    nout_enq_w = 1'b0;
    bus_enq_w  = 1'b0;
    alu_en_w   = 1'b0;
    done_w     = 1'b0;
    // Strobes are gated by reset so nothing fires while reset is held low.
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          if (!sif.ctrl_fifo_empty) begin
            ctrl_deq_w = 1'b1;
            inst_d     = sif.ctrl_fifo_data_out;
            state_d    = S_OP0;
          end
        end
        S_OP0: begin
          if (src_ready_w) begin
            int_deq_w = (sel_w == SEL_INT);
            nin_deq_w = (sel_w == SEL_NIN);
            op0_d     = src_val_w;
            state_d   = S_OP1;
          end
        end
        S_OP1: begin
          if (src_ready_w) begin
            int_deq_w = (sel_w == SEL_INT);
            nin_deq_w = (sel_w == SEL_NIN);
            alu_op0_d = op0_q;
            alu_op1_d = src_val_w;
            alu_opc_d = opcode_w;
            state_d   = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_en_w = 1'b1;
          result_d = sif.alu_out;
          acc_d    = sif.alu_out;
          state_d  = S_WB;
        end
        S_WB: begin
          if (wb_ready_w) begin
            nout_enq_w = dst0_w;
            bus_enq_w  = dst1_w;
            done_w     = 1'b1;
            state_d    = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      inst_q    <= '0;
      op0_q     <= '0;
      alu_op0_q <= '0;
      alu_op1_q <= '0;
      alu_opc_q <= '0;
      acc_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      op0_q     <= op0_d;
      alu_op0_q <= alu_op0_d;
      alu_op1_q <= alu_op1_d;
      alu_opc_q <= alu_opc_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
    end
  end

  assign sif.ctrl_fifo_deq     = ctrl_deq_w;
  assign sif.int_fifo_deq      = int_deq_w;
  assign sif.nin_fifo_deq      = nin_deq_w;
  assign sif.nout_fifo_enq     = nout_enq_w;
  assign sif.bus_fifo_enq      = bus_enq_w;
  assign sif.nout_fifo_data_in = result_q;
  assign sif.bus_fifo_data_in  = result_q;
  assign sif.alu_enable        = alu_en_w;
  assign sif.alu_op_code       = alu_opc_q;
  assign sif.alu_op0           = alu_op0_q;
  assign sif.alu_op1           = alu_op1_q;
  assign sif.busy              = (state_q != S_FETCH);
  assign sif.inst_done         = done_w;

`ifdef INST_SEQ_PERF_CNT_EN
  logic        stall_w;
  logic [15:0] retired_q, stall_q;

  assign stall_w = (((state_q == S_OP0) || (state_q == S_OP1)) && !src_ready_w)
                   || ((state_q == S_WB) && !wb_ready_w);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (done_w && (retired_q != 16'hFFFF)) retired_q <= retired_q + 16'd1;
      if (stall_w && (stall_q != 16'hFFFF))  stall_q   <= stall_q + 16'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_inst_sequencer : directed bench with FWFT FIFO models and an ALU stub    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_inst_sequencer;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  logic [7:0] ctrl_q[$];
  logic [3:0] int_q[$];
  logic [3:0] nin_q[$];
  logic [3:0] nout_log[$];
  logic [3:0] bus_log[$];

  inst_sequencer_if sif ();

`ifdef INST_SEQ_PERF_CNT_EN
  logic [15:0] retired_cnt;
  logic [15:0] stall_cnt;
`endif

  inst_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .sif         (sif)
`ifdef INST_SEQ_PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  function automatic logic [3:0] alu_stub(input logic [1:0] opc, input logic [3:0] a, input logic [3:0] b);
    case (opc)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  assign sif.alu_out = alu_stub(sif.alu_op_code, sif.alu_op0, sif.alu_op1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] strobes();
    return {sif.ctrl_fifo_deq, sif.int_fifo_deq, sif.nin_fifo_deq, sif.nout_fifo_enq,
            sif.bus_fifo_enq, sif.alu_enable, sif.busy, sif.inst_done};
  endfunction

  task automatic refresh();
    sif.ctrl_fifo_empty    = (ctrl_q.size() == 0);
    sif.ctrl_fifo_data_out = (ctrl_q.size() == 0) ? 8'h00 : ctrl_q[0];
    sif.int_fifo_empty     = (int_q.size() == 0);
    sif.int_fifo_data_out  = (int_q.size() == 0) ? 4'h0 : int_q[0];
    sif.nin_fifo_empty     = (nin_q.size() == 0);
    sif.nin_fifo_data_out  = (nin_q.size() == 0) ? 4'h0 : nin_q[0];
    #1;
  endtask

  // Advance one clock, applying the FIFO side effects of the strobes seen just before the edge.
  task automatic step();
    logic       cd, id, nd, ne, be, nf, bf, bad;
    logic [3:0] dat;
    #1;
    cd = sif.ctrl_fifo_deq; id = sif.int_fifo_deq; nd = sif.nin_fifo_deq;
    ne = sif.nout_fifo_enq; be = sif.bus_fifo_enq;
    nf = sif.nout_fifo_full; bf = sif.bus_fifo_full; dat = sif.nout_fifo_data_in;
    bad = 1'b0;
    @(posedge clk);
    if (cd) begin if (ctrl_q.size() == 0) bad = 1'b1; else void'(ctrl_q.pop_front()); end
    if (id) begin if (int_q.size() == 0)  bad = 1'b1; else void'(int_q.pop_front());  end
    if (nd) begin if (nin_q.size() == 0)  bad = 1'b1; else void'(nin_q.pop_front());  end
    if (ne) begin if (nf) bad = 1'b1; nout_log.push_back(dat); end
    if (be) begin if (bf) bad = 1'b1; bus_log.push_back(dat); end
    #1;
    refresh();
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_protocol: violation=%b required 0 at %0t", bad, $time);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sif.nout_fifo_full = 1'b0;
    sif.bus_fifo_full  = 1'b0;
    ctrl_q.push_back(8'h0E);
    int_q.push_back(4'd1);
    refresh();
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (strobes() !== 8'h00) begin
      n_fail++; $display("FAIL reset_strobes: got %b required 00000000", strobes());
    end
    n_tests++;
    if ({sif.nout_fifo_data_in, sif.bus_fifo_data_in, sif.alu_op0, sif.alu_op1, sif.alu_op_code} !== 18'h0) begin
      n_fail++; $display("FAIL reset_data: got %h required 0",
                         {sif.nout_fifo_data_in, sif.bus_fifo_data_in, sif.alu_op0, sif.alu_op1, sif.alu_op_code});
    end
    ctrl_q.delete();
    int_q.delete();
    refresh();
    @(negedge clk);
    reset = 1'b1;
    step();
    n_tests++;
    if (strobes() !== 8'h00) begin
      n_fail++; $display("FAIL idle_after_reset: got %b required 00000000", strobes());
    end
  endtask

  task automatic test_basic_add();
    nout_log.delete(); bus_log.delete();
    int_q.push_back(4'd3); nin_q.push_back(4'd4); ctrl_q.push_back(8'b00_00_01_1_0);
    refresh();
    n_tests++;
    if (sif.ctrl_fifo_deq !== 1'b1) begin n_fail++; $display("FAIL add_ctrl_deq: got %b required 1", sif.ctrl_fifo_deq); end
    step();
    n_tests++;
    if ({sif.int_fifo_deq, sif.nin_fifo_deq, sif.busy} !== 3'b101) begin
      n_fail++; $display("FAIL add_op0: got %b required 101", {sif.int_fifo_deq, sif.nin_fifo_deq, sif.busy});
    end
    step();
    n_tests++;
    if ({sif.int_fifo_deq, sif.nin_fifo_deq} !== 2'b01) begin
      n_fail++; $display("FAIL add_op1: got %b required 01", {sif.int_fifo_deq, sif.nin_fifo_deq});
    end
    step();
    n_tests++;
    if ({sif.alu_enable, sif.alu_op_code, sif.alu_op0, sif.alu_op1} !== {1'b1, 2'b00, 4'd3, 4'd4}) begin
      n_fail++; $display("FAIL add_exec: got en=%b opc=%0d a=%0d b=%0d required en=1 opc=0 a=3 b=4",
                         sif.alu_enable, sif.alu_op_code, sif.alu_op0, sif.alu_op1);
    end
    step();
    n_tests++;
    if ({sif.nout_fifo_enq, sif.bus_fifo_enq, sif.inst_done, sif.nout_fifo_data_in} !== {3'b101, 4'd7}) begin
      n_fail++; $display("FAIL add_wb: got nout=%b bus=%b done=%b data=%0d required 1 0 1 7",
                         sif.nout_fifo_enq, sif.bus_fifo_enq, sif.inst_done, sif.nout_fifo_data_in);
    end
    step();
    n_tests++;
    if (strobes() !== 8'h00 || nout_log.size() != 1 || bus_log.size() != 0) begin
      n_fail++; $display("FAIL add_retire: strobes=%b nout_n=%0d bus_n=%0d required 0 1 0",
                         strobes(), nout_log.size(), bus_log.size());
    end else begin
      n_tests++;
      if (nout_log[0] !== 4'd7) begin n_fail++; $display("FAIL add_value: got %0d required 7", nout_log[0]); end
    end
  endtask

  task automatic test_same_source();
    nout_log.delete(); bus_log.delete();
    int_q.push_back(4'd2); int_q.push_back(4'd5); ctrl_q.push_back(8'b00_00_00_0_1);
    refresh();
    step();
    n_tests++;
    if (sif.int_fifo_deq !== 1'b1) begin n_fail++; $display("FAIL same_op0_deq: got %b required 1", sif.int_fifo_deq); end
    step();
    n_tests++;
    if (sif.int_fifo_deq !== 1'b1) begin n_fail++; $display("FAIL same_op1_deq: got %b required 1", sif.int_fifo_deq); end
    step();
    step();
    n_tests++;
    if ({sif.bus_fifo_enq, sif.nout_fifo_enq, sif.bus_fifo_data_in} !== {2'b10, 4'd7}) begin
      n_fail++; $display("FAIL same_wb: got bus=%b nout=%b data=%0d required 1 0 7",
                         sif.bus_fifo_enq, sif.nout_fifo_enq, sif.bus_fifo_data_in);
    end
    step();
    n_tests++;
    if (int_q.size() != 0 || bus_log.size() != 1 || sif.int_fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL same_end: int_n=%0d bus_n=%0d required 0 1", int_q.size(), bus_log.size());
    end
  endtask

  task automatic test_operand_stall();
    logic [15:0] s0;
    nout_log.delete(); bus_log.delete();
    ctrl_q.push_back(8'b00_01_11_1_0);
    refresh();
    step();
`ifdef INST_SEQ_PERF_CNT_EN
    s0 = stall_cnt;
`else
    s0 = 16'd0;
`endif
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if ({sif.nin_fifo_deq, sif.int_fifo_deq, sif.alu_enable, sif.busy, sif.nout_fifo_enq} !== 5'b00010) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got %b required 00010", i,
                           {sif.nin_fifo_deq, sif.int_fifo_deq, sif.alu_enable, sif.busy, sif.nout_fifo_enq});
      end
      step();
    end
`ifdef INST_SEQ_PERF_CNT_EN
    n_tests++;
    if (stall_cnt !== s0 + 16'd10) begin n_fail++; $display("FAIL stall_cnt_op0: got %0d required %0d", stall_cnt, s0 + 16'd10); end
`endif
    nin_q.push_back(4'd9);
    refresh();
    n_tests++;
    if (sif.nin_fifo_deq !== 1'b1) begin n_fail++; $display("FAIL stall_release_deq: got %b required 1", sif.nin_fifo_deq); end
    repeat (3) step();
    n_tests++;
    if ({sif.nout_fifo_enq, sif.nout_fifo_data_in, sif.inst_done} !== {1'b1, 4'd9, 1'b1}) begin
      n_fail++; $display("FAIL stall_wb: got enq=%b data=%0d done=%b required 1 9 1",
                         sif.nout_fifo_enq, sif.nout_fifo_data_in, sif.inst_done);
    end
    step();
  endtask

  task automatic test_acc_overflow();
    nout_log.delete(); bus_log.delete();
    int_q.push_back(4'd15); int_q.push_back(4'd2);
    ctrl_q.push_back(8'b00_00_11_0_0); ctrl_q.push_back(8'b00_10_00_1_1);
    refresh();
    repeat (4) step();
    n_tests++;
    if ({sif.inst_done, sif.nout_fifo_enq, sif.bus_fifo_enq} !== 3'b100) begin
      n_fail++; $display("FAIL accA_wb: got %b required 100", {sif.inst_done, sif.nout_fifo_enq, sif.bus_fifo_enq});
    end
    step();
    n_tests++;
    if (sif.ctrl_fifo_deq !== 1'b1) begin n_fail++; $display("FAIL accB_fetch: got %b required 1", sif.ctrl_fifo_deq); end
    step();
    n_tests++;
    if (sif.int_fifo_deq !== 1'b0) begin n_fail++; $display("FAIL accB_op0_nopop: got %b required 0", sif.int_fifo_deq); end
    step();
    step();
    n_tests++;
    if ({sif.alu_op0, sif.alu_op1} !== {4'd15, 4'd2}) begin
      n_fail++; $display("FAIL accB_exec: got a=%0d b=%0d required a=15 b=2", sif.alu_op0, sif.alu_op1);
    end
    step();
    n_tests++;
    if ({sif.nout_fifo_enq, sif.bus_fifo_enq, sif.nout_fifo_data_in, sif.bus_fifo_data_in} !== {2'b11, 4'd1, 4'd1}) begin
      n_fail++; $display("FAIL accB_wb: got nout=%b bus=%b data=%0d/%0d required 1 1 1/1",
                         sif.nout_fifo_enq, sif.bus_fifo_enq, sif.nout_fifo_data_in, sif.bus_fifo_data_in);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [15:0] s0, r0;
    nout_log.delete(); bus_log.delete();
    sif.bus_fifo_full = 1'b1;
    int_q.push_back(4'd6); ctrl_q.push_back(8'b00_00_11_0_1);
    refresh();
    repeat (4) step();
`ifdef INST_SEQ_PERF_CNT_EN
    s0 = stall_cnt; r0 = retired_cnt;
`else
    s0 = 16'd0; r0 = 16'd0;
`endif
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if ({sif.bus_fifo_enq, sif.busy, sif.inst_done} !== 3'b010) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got %b required 010", i, {sif.bus_fifo_enq, sif.busy, sif.inst_done});
      end
      step();
    end
    sif.bus_fifo_full = 1'b0;
    #1;
    n_tests++;
    if ({sif.bus_fifo_enq, sif.inst_done, sif.bus_fifo_data_in} !== {2'b11, 4'd6}) begin
      n_fail++; $display("FAIL bp_release: got enq=%b done=%b data=%0d required 1 1 6",
                         sif.bus_fifo_enq, sif.inst_done, sif.bus_fifo_data_in);
    end
`ifdef INST_SEQ_PERF_CNT_EN
    n_tests++;
    if (stall_cnt !== s0 + 16'd6) begin n_fail++; $display("FAIL bp_stall_cnt: got %0d required %0d", stall_cnt, s0 + 16'd6); end
`endif
    step();
`ifdef INST_SEQ_PERF_CNT_EN
    n_tests++;
    if (retired_cnt !== r0 + 16'd1) begin n_fail++; $display("FAIL bp_retired_cnt: got %0d required %0d", retired_cnt, r0 + 16'd1); end
`endif
    n_tests++;
    if (bus_log.size() != 1 || sif.busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_once: bus_n=%0d busy=%b required 1 0", bus_log.size(), sif.busy);
    end
  endtask

  task automatic test_back_to_back();
    nout_log.delete(); bus_log.delete();
    int_q.push_back(4'd4); int_q.push_back(4'd8);
    ctrl_q.push_back(8'b00_00_11_1_0); ctrl_q.push_back(8'b00_00_11_0_1);
    refresh();
    repeat (4) step();
    n_tests++;
    if ({sif.nout_fifo_enq, sif.inst_done, sif.nout_fifo_data_in} !== {2'b11, 4'd4}) begin
      n_fail++; $display("FAIL b2b_first: got enq=%b done=%b data=%0d required 1 1 4",
                         sif.nout_fifo_enq, sif.inst_done, sif.nout_fifo_data_in);
    end
    step();
    n_tests++;
    if (sif.ctrl_fifo_deq !== 1'b1) begin n_fail++; $display("FAIL b2b_fetch: got %b required 1", sif.ctrl_fifo_deq); end
    repeat (4) step();
    n_tests++;
    if ({sif.bus_fifo_enq, sif.nout_fifo_enq, sif.bus_fifo_data_in} !== {2'b10, 4'd8}) begin
      n_fail++; $display("FAIL b2b_second: got bus=%b nout=%b data=%0d required 1 0 8",
                         sif.bus_fifo_enq, sif.nout_fifo_enq, sif.bus_fifo_data_in);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    nout_log.delete(); bus_log.delete();
    int_q.push_back(4'd5); int_q.push_back(4'd3);
    ctrl_q.push_back(8'b00_00_11_1_0);
    refresh();
    repeat (3) step();
    n_tests++;
    if (sif.alu_enable !== 1'b1) begin n_fail++; $display("FAIL rst_in_exec: got %b required 1", sif.alu_enable); end
    reset = 1'b0;
    #1;
    n_tests++;
    if (strobes() !== 8'h00) begin n_fail++; $display("FAIL rst_async: got %b required 00000000", strobes()); end
    step();
    reset = 1'b1;
    step();
    n_tests++;
    if (nout_log.size() != 0 || int_q.size() != 1) begin
      n_fail++; $display("FAIL rst_dropped: nout_n=%0d int_n=%0d required 0 1", nout_log.size(), int_q.size());
    end
    ctrl_q.push_back(8'b00_10_00_1_0);
    refresh();
    repeat (3) step();
    n_tests++;
    if ({sif.alu_op0, sif.alu_op1} !== {4'd0, 4'd3}) begin
      n_fail++; $display("FAIL rst_acc_zero: got a=%0d b=%0d required a=0 b=3", sif.alu_op0, sif.alu_op1);
    end
    step();
    n_tests++;
    if ({sif.nout_fifo_enq, sif.nout_fifo_data_in} !== {1'b1, 4'd3}) begin
      n_fail++; $display("FAIL rst_next_wb: got enq=%b data=%0d required 1 3", sif.nout_fifo_enq, sif.nout_fifo_data_in);
    end
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic_add();
    test_same_source();
    test_operand_stall();
    test_acc_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
